capi_tag_issue: RTL and testbench
=================================

Name: capi_tag_issue

Overview:
- Sits directly downstream of the tag resource manager.
- Pairs each incoming command request with a free tag from the manager's avail interface, records the request context in a tag-indexed table, and issues the tagged command.
- On each response, looks up the context by tag, emits a completion, and returns the tag to the manager's free interface.
- Provides outstanding-count tracking and a drain/quiesce state machine for reset-recovery sequencing.

Parameters:
- id_width, 4, tag width in bits (no parity bit)
- num_res, 2**id_width, number of tags and table entries
- dwidth, 32, request context width stored per tag

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req_v  in  1  request valid
- i_req_r  out  1  request ready
- i_req_d  in  dwidth  request context
- i_tag_v  in  1  free tag available (from manager o_avail_v)
- i_tag_r  out  1  tag consumed (to manager o_avail_r)
- i_tag_id  in  id_width  free tag
- o_cmd_v  out  1  tagged command valid
- o_cmd_r  in  1  command ready
- o_cmd_tag  out  id_width  command tag
- o_cmd_d  out  dwidth  command context
- i_rsp_v  in  1  response valid; no backpressure
- i_rsp_tag  in  id_width  response tag
- o_cpl_v  out  1  completion pulse
- o_cpl_tag  out  id_width  completed tag
- o_cpl_d  out  dwidth  stored context for the completed tag
- o_free_v  out  1  tag return (to manager i_free_v)
- o_free_id  out  id_width  returned tag (to manager i_free_id)
- i_drain  in  1  level; stop issuing new commands
- o_idle  out  1  drained and zero outstanding
- o_cnt  out  id_width+1  outstanding tag count
- o_rsp_err  out  1  sticky: response to a tag not outstanding

Behaviour:
- Reset values (synchronous, active-high):
  - o_cmd_v, o_cpl_v, o_free_v, o_rsp_err, o_cnt = 0; o_idle = 0.
  - All per-tag valid bits cleared; state = RUN.
  - Context table RAM is not reset.
- Issue:
  - fire = i_req_v & i_tag_v & (state==RUN) & (~o_cmd_v | o_cmd_r).
  - i_req_r = i_tag_r = fire; both handshakes complete in the same cycle, never one without the other.
  - On fire:
    - table[i_tag_id] <= i_req_d and valid[i_tag_id] <= 1.
    - Output register loads {i_tag_id, i_req_d}; o_cmd_v = 1 the next cycle.
  - Latency is 1 cycle, request to command.
  - o_cmd_v, o_cmd_tag and o_cmd_d hold stable until o_cmd_r. Back-to-back issue at full rate when o_cmd_r = 1.
- Response pipeline, 2 stages:
  - r1: register i_rsp_v and i_rsp_tag; read table and valid at i_rsp_tag.
  - r2: if the valid bit was set:
    - o_cpl_v = o_free_v = 1, with o_cpl_tag = o_free_id = tag and o_cpl_d = table data.
    - Clear valid[tag] at r1 so that a duplicate response arriving in the next cycle is detected.
  - If the valid bit was clear: set o_rsp_err (cleared only by reset); no completion, no free.
  - Latency is 2 cycles, response to completion/free; one response per cycle is sustained.
- Same-cycle collisions:
  - Issue write and response read to the same tag: response sees the old valid value (0), which sets o_rsp_err.
  - Issue of tag A and response of tag B in the same cycle are independent; both proceed.
- o_cnt:
  - +1 on fire; -1 on o_free_v; unchanged when both occur.
  - Never exceeds num_res, because the manager never hands out more than num_res tags.
- Drain state machine:
  - RUN -> DRAIN when i_drain = 1.
  - DRAIN -> IDLE when o_cnt == 0 & ~o_cmd_v & r1 and r2 are empty.
  - IDLE -> RUN when i_drain = 0.
  - DRAIN -> RUN when i_drain deasserts before idle.
  - o_idle = (state == IDLE), registered.
  - Responses are processed in every state.
- Reset mid-operation:
  - All outstanding tags are forgotten.
  - The manager is reset with the same reset, so no free is issued for them.

Decomposition:
- No shared package required.
- Optional sub-module capi_tag_ctx_tbl: num_res x dwidth context RAM plus valid-bit array with set/clear/read ports.
- Use the codebase's base_incdec for o_cnt.

Test Plan:
- Reset, then present 3 requests with contexts 0xA0, 0xA1, 0xA2 and tags 5, 6, 7, o_cmd_r = 1 -> commands (5,0xA0), (6,0xA1), (7,0xA2) on consecutive cycles, 1 cycle after each fire; o_cnt = 3.
- Hold o_cmd_r = 0 with a request and tag both valid -> one command issues, then i_req_r = i_tag_r = 0 and o_cmd_* stay stable until o_cmd_r = 1.
- Response tag 6 -> 2 cycles later o_cpl_v = o_free_v = 1 with tag 6 and data 0xA1; o_cnt = 2.
- Response tag 6 repeated on the next cycle -> o_rsp_err = 1 and stays 1; no second free.
- Same cycle: issue tag 3 and response tag 5 -> tag 5 completes; command for tag 3 issues; o_cnt unchanged.
- Assert i_drain with 2 tags outstanding -> i_req_r = 0, o_idle = 0. After both responses, o_idle = 1 within 2 cycles of the last free. Deassert i_drain -> state returns to RUN and issue resumes.

Source files
------------

// File: rtl/capi_tag_issue_pkg.sv
// Shared types for the CAPI tag issue block: drain/quiesce state encoding.
package capi_tag_issue_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_IDLE  = 2'd2
    } drain_state_e;

endpackage

// File: rtl/base_incdec.sv
// Up/down counter: +1 on inc, -1 on dec, hold when both or neither.
module base_incdec #(
    parameter int width = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [width-1:0] cnt
);

    localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

    // counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= {width{1'b0}};
        end else if (inc && !dec) begin
            cnt <= cnt + ONE;
        end else if (dec && !inc) begin
            cnt <= cnt - ONE;
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/capi_tag_ctx_tbl.sv
// Tag-indexed context RAM plus per-tag valid bits; registered read returns pre-write values.
module capi_tag_ctx_tbl #(
    parameter int id_width = 4,
    parameter int num_res  = 2**id_width,
    parameter int dwidth   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                set_v,
    input  logic [id_width-1:0] set_idx,
    input  logic [dwidth-1:0]   set_d,
    input  logic                clr_v,
    input  logic [id_width-1:0] clr_idx,
    input  logic [id_width-1:0] rd_idx,
    output logic                rd_valid,
    output logic [dwidth-1:0]   rd_d
);

    localparam logic [num_res-1:0] ONE_HOT0 = {{(num_res-1){1'b0}}, 1'b1};

    logic [dwidth-1:0]  mem_r [num_res];
    logic [num_res-1:0] valid_r;
    logic [num_res-1:0] set_mask_s;
    logic [num_res-1:0] clr_mask_s;
    logic [num_res-1:0] valid_nx_s;

    // set wins over clear so a same-cycle reissue of a just-responded tag stays valid
    always_comb begin
        set_mask_s = set_v ? (ONE_HOT0 << set_idx) : {num_res{1'b0}};
        clr_mask_s = clr_v ? (ONE_HOT0 << clr_idx) : {num_res{1'b0}};
        valid_nx_s = (valid_r & ~clr_mask_s) | set_mask_s;
    end

    // valid bits and registered valid read
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r  <= {num_res{1'b0}};
            rd_valid <= 1'b0;
        end else begin
            valid_r  <= valid_nx_s;
            rd_valid <= valid_r[rd_idx];
        end
    end

    // context RAM, intentionally not reset
    always_ff @(posedge clk) begin
        if (set_v) begin
            mem_r[set_idx] <= set_d;
        end
        rd_d <= mem_r[rd_idx];
    end

endmodule

// File: rtl/capi_tag_issue.sv
// Pairs requests with free tags, issues tagged commands, completes responses and
// returns tags to the manager; includes outstanding count and drain/quiesce FSM.
module capi_tag_issue
    import capi_tag_issue_pkg::*;
#(
    parameter int id_width = 4,
    parameter int num_res  = 2**id_width,
    parameter int dwidth   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req_v,
    output logic                i_req_r,
    input  logic [dwidth-1:0]   i_req_d,
    input  logic                i_tag_v,
    output logic                i_tag_r,
    input  logic [id_width-1:0] i_tag_id,
    output logic                o_cmd_v,
    input  logic                o_cmd_r,
    output logic [id_width-1:0] o_cmd_tag,
    output logic [dwidth-1:0]   o_cmd_d,
    input  logic                i_rsp_v,
    input  logic [id_width-1:0] i_rsp_tag,
    output logic                o_cpl_v,
    output logic [id_width-1:0] o_cpl_tag,
    output logic [dwidth-1:0]   o_cpl_d,
    output logic                o_free_v,
    output logic [id_width-1:0] o_free_id,
    input  logic                i_drain,
    output logic                o_idle,
    output logic [id_width:0]   o_cnt,
    output logic                o_rsp_err
);

    drain_state_e          state_r;
    drain_state_e          state_nx_s;
    logic                  fire_s;
    logic                  quiet_s;
    logic                  cmd_v_r;
    logic [id_width-1:0]   cmd_tag_r;
    logic [dwidth-1:0]     cmd_d_r;
    logic                  rsp_v_r1;
    logic [id_width-1:0]   rsp_tag_r1;
    logic                  tbl_valid_s;
    logic [dwidth-1:0]     tbl_d_s;
    logic                  cpl_v_r;
    logic [id_width-1:0]   cpl_tag_r;
    logic [dwidth-1:0]     cpl_d_r;
    logic                  rsp_err_r;
    logic                  idle_r;
    logic [id_width:0]     cnt_s;

    // issue handshake: request and tag are always consumed together
    always_comb begin
        fire_s  = i_req_v & i_tag_v & (state_r == ST_RUN) & (~cmd_v_r | o_cmd_r);
        quiet_s = (cnt_s == {(id_width+1){1'b0}}) & ~cmd_v_r & ~rsp_v_r1 & ~cpl_v_r;
    end

    assign i_req_r   = fire_s;
    assign i_tag_r   = fire_s;
    assign o_cmd_v   = cmd_v_r;
    assign o_cmd_tag = cmd_tag_r;
    assign o_cmd_d   = cmd_d_r;
    assign o_cpl_v   = cpl_v_r;
    assign o_cpl_tag = cpl_tag_r;
    assign o_cpl_d   = cpl_d_r;
    assign o_free_v  = cpl_v_r;
    assign o_free_id = cpl_tag_r;
    assign o_rsp_err = rsp_err_r;
    assign o_idle    = idle_r;
    assign o_cnt     = cnt_s;

    capi_tag_ctx_tbl #(
        .id_width (id_width),
        .num_res  (num_res),
        .dwidth   (dwidth)
    ) u_tbl (
        .clk      (clk),
        .reset    (reset),
        .set_v    (fire_s),
        .set_idx  (i_tag_id),
        .set_d    (i_req_d),
        .clr_v    (i_rsp_v),
        .clr_idx  (i_rsp_tag),
        .rd_idx   (i_rsp_tag),
        .rd_valid (tbl_valid_s),
        .rd_d     (tbl_d_s)
    );

    base_incdec #(
        .width (id_width + 1)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (fire_s),
        .dec   (cpl_v_r),
        .cnt   (cnt_s)
    );

    // command output register, held until accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_v_r   <= 1'b0;
            cmd_tag_r <= {id_width{1'b0}};
            cmd_d_r   <= {dwidth{1'b0}};
        end else if (fire_s) begin
            cmd_v_r   <= 1'b1;
            cmd_tag_r <= i_tag_id;
            cmd_d_r   <= i_req_d;
        end else if (o_cmd_r) begin
            cmd_v_r   <= 1'b0;
        end else begin
            cmd_v_r   <= cmd_v_r;
        end
    end

    // response pipeline: r1 captures the lookup, r2 drives completion/free or flags an error
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_v_r1   <= 1'b0;
            rsp_tag_r1 <= {id_width{1'b0}};
            cpl_v_r    <= 1'b0;
            cpl_tag_r  <= {id_width{1'b0}};
            cpl_d_r    <= {dwidth{1'b0}};
            rsp_err_r  <= 1'b0;
        end else begin
            rsp_v_r1   <= i_rsp_v;
            rsp_tag_r1 <= i_rsp_tag;
            cpl_v_r    <= rsp_v_r1 & tbl_valid_s;
            cpl_tag_r  <= rsp_tag_r1;
            cpl_d_r    <= tbl_d_s;
            rsp_err_r  <= rsp_err_r | (rsp_v_r1 & ~tbl_valid_s);
        end
    end

    // drain FSM next state
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (i_drain) state_nx_s = ST_DRAIN;
                else         state_nx_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (!i_drain)    state_nx_s = ST_RUN;
                else if (quiet_s) state_nx_s = ST_IDLE;
                else             state_nx_s = ST_DRAIN;
            end
            ST_IDLE: begin
                if (!i_drain) state_nx_s = ST_RUN;
                else          state_nx_s = ST_IDLE;
            end
            default: state_nx_s = ST_RUN;
        endcase
    end

    // drain FSM state and registered idle flag (aligned with the state it reports)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_RUN;
            idle_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            idle_r  <= (state_nx_s == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_capi_tag_issue.sv
// Scoreboard bench for capi_tag_issue: expected commands/completions queued at stimulus time.
module tb_capi_tag_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req_v, i_req_r, i_tag_v, i_tag_r;
    logic [31:0] i_req_d;
    logic [3:0]  i_tag_id;
    logic        o_cmd_v, o_cmd_r;
    logic [3:0]  o_cmd_tag;
    logic [31:0] o_cmd_d;
    logic        i_rsp_v;
    logic [3:0]  i_rsp_tag;
    logic        o_cpl_v;
    logic [3:0]  o_cpl_tag;
    logic [31:0] o_cpl_d;
    logic        o_free_v;
    logic [3:0]  o_free_id;
    logic        i_drain, o_idle, o_rsp_err;
    logic [4:0]  o_cnt;

    always #5 clk = ~clk;

    capi_tag_issue #(.id_width(4), .num_res(16), .dwidth(32)) dut (
        .clk(clk), .reset(reset),
        .i_req_v(i_req_v), .i_req_r(i_req_r), .i_req_d(i_req_d),
        .i_tag_v(i_tag_v), .i_tag_r(i_tag_r), .i_tag_id(i_tag_id),
        .o_cmd_v(o_cmd_v), .o_cmd_r(o_cmd_r), .o_cmd_tag(o_cmd_tag), .o_cmd_d(o_cmd_d),
        .i_rsp_v(i_rsp_v), .i_rsp_tag(i_rsp_tag),
        .o_cpl_v(o_cpl_v), .o_cpl_tag(o_cpl_tag), .o_cpl_d(o_cpl_d),
        .o_free_v(o_free_v), .o_free_id(o_free_id),
        .i_drain(i_drain), .o_idle(o_idle), .o_cnt(o_cnt), .o_rsp_err(o_rsp_err)
    );

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [35:0] cmd_q[$];
    int          cmd_cyc_q[$];
    bit          cmd_shown = 1'b0;
    logic [35:0] cpl_q[$];
    int          cpl_cyc_q[$];
    logic [31:0] m_ctx [16];
    bit          m_valid [16];
    int          err_cyc = -1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: compare outputs against queued expectations, then queue new ones
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_cmd_v) begin
                if (cmd_q.size() == 0) begin
                    chk("cmd_unexpected", 64'd1, 64'd0);
                end else begin
                    chk("cmd_tag_d", 64'({o_cmd_tag, o_cmd_d}), 64'(cmd_q[0]));
                    if (!cmd_shown) begin
                        chk("cmd_latency", 64'(cyc), 64'(cmd_cyc_q[0]));
                        cmd_shown = 1'b1;
                    end
                    if (o_cmd_r) begin
                        void'(cmd_q.pop_front());
                        void'(cmd_cyc_q.pop_front());
                        cmd_shown = 1'b0;
                    end
                end
            end else if (cmd_q.size() != 0 && cyc >= cmd_cyc_q[0]) begin
                chk("cmd_missing", 64'd0, 64'd1);
                void'(cmd_q.pop_front());
                void'(cmd_cyc_q.pop_front());
                cmd_shown = 1'b0;
            end

            if (o_cpl_v) begin
                if (cpl_q.size() == 0) begin
                    chk("cpl_unexpected", 64'd1, 64'd0);
                end else begin
                    chk("cpl_tag_d", 64'({o_cpl_tag, o_cpl_d}), 64'(cpl_q[0]));
                    chk("cpl_latency", 64'(cyc), 64'(cpl_cyc_q[0]));
                    chk("free_v", 64'(o_free_v), 64'd1);
                    chk("free_id", 64'(o_free_id), 64'(cpl_q[0][35:32]));
                    void'(cpl_q.pop_front());
                    void'(cpl_cyc_q.pop_front());
                end
            end else begin
                if (o_free_v) chk("free_unexpected", 64'd1, 64'd0);
                if (cpl_q.size() != 0 && cyc >= cpl_cyc_q[0]) begin
                    chk("cpl_missing", 64'd0, 64'd1);
                    void'(cpl_q.pop_front());
                    void'(cpl_cyc_q.pop_front());
                end
            end

            chk("rsp_err", 64'(o_rsp_err), 64'(err_cyc >= 0 && cyc >= err_cyc));

            // response handled before issue: a same-cycle issue must not validate the lookup
            if (i_rsp_v) begin
                if (m_valid[i_rsp_tag]) begin
                    cpl_q.push_back({i_rsp_tag, m_ctx[i_rsp_tag]});
                    cpl_cyc_q.push_back(cyc + 2);
                    m_valid[i_rsp_tag] = 1'b0;
                end else if (err_cyc < 0) begin
                    err_cyc = cyc + 2;
                end
            end
            if (i_req_v && i_req_r) begin
                cmd_q.push_back({i_tag_id, i_req_d});
                cmd_cyc_q.push_back(cyc + 1);
                m_valid[i_tag_id] = 1'b1;
                m_ctx[i_tag_id]   = i_req_d;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] tag, input logic [31:0] d, input logic exp_fire);
        i_req_v  = 1'b1;
        i_tag_v  = 1'b1;
        i_tag_id = tag;
        i_req_d  = d;
        #1;
        chk("req_r", 64'(i_req_r), 64'(exp_fire));
        chk("tag_r", 64'(i_tag_r), 64'(exp_fire));
    endtask

    task automatic no_req();
        i_req_v = 1'b0;
        i_tag_v = 1'b0;
    endtask

    task automatic rsp(input logic [3:0] tag);
        i_rsp_v   = 1'b1;
        i_rsp_tag = tag;
    endtask

    initial begin
        reset = 1'b1;
        i_req_v = 1'b0; i_tag_v = 1'b0; i_req_d = 32'd0; i_tag_id = 4'd0;
        o_cmd_r = 1'b0; i_rsp_v = 1'b0; i_rsp_tag = 4'd0; i_drain = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctx[i]   = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_v", 64'(o_cmd_v), 64'd0);
        chk("rst_cpl_v", 64'(o_cpl_v), 64'd0);
        chk("rst_free_v", 64'(o_free_v), 64'd0);
        chk("rst_rsp_err", 64'(o_rsp_err), 64'd0);
        chk("rst_cnt", 64'(o_cnt), 64'd0);
        chk("rst_idle", 64'(o_idle), 64'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        step();

        // three back-to-back issues
        o_cmd_r = 1'b1;
        issue(4'd5, 32'hA0, 1'b1); step();
        issue(4'd6, 32'hA1, 1'b1); step();
        issue(4'd7, 32'hA2, 1'b1); step();
        no_req(); step(); step();
        chk("cnt_after_3", 64'(o_cnt), 64'd3);

        // backpressure: one issues, the next waits for the command register
        o_cmd_r = 1'b0;
        issue(4'd9, 32'hB9, 1'b1); step();
        issue(4'd10, 32'hBA, 1'b0); step();
        chk("bp_req_r", 64'(i_req_r), 64'd0);
        step(); step();
        chk("bp_cmd_held_tag", 64'(o_cmd_tag), 64'd9);
        o_cmd_r = 1'b1;
        #1;
        chk("bp_release_req_r", 64'(i_req_r), 64'd1);
        step();
        no_req(); step(); step();
        chk("cnt_after_bp", 64'(o_cnt), 64'd5);

        // response then duplicate on the next cycle
        rsp(4'd6); step();
        step();
        i_rsp_v = 1'b0;
        step(); step(); step();
        chk("cnt_after_rsp6", 64'(o_cnt), 64'd4);
        chk("dup_err", 64'(o_rsp_err), 64'd1);

        // same-cycle issue of tag 3 and response of tag 5
        rsp(4'd5);
        issue(4'd3, 32'hC3, 1'b1); step();
        no_req(); i_rsp_v = 1'b0;
        repeat (4) step();
        chk("cnt_same_cycle", 64'(o_cnt), 64'd4);

        rsp(4'd9); step();
        rsp(4'd10); step();
        i_rsp_v = 1'b0;
        repeat (3) step();
        chk("cnt_before_drain", 64'(o_cnt), 64'd2);

        // drain with tags 7 and 3 outstanding
        i_drain = 1'b1;
        step(); step();
        issue(4'd14, 32'hE0, 1'b0);
        chk("drain_idle_lo", 64'(o_idle), 64'd0);
        step();
        no_req();
        rsp(4'd7); step();
        rsp(4'd3); step();
        i_rsp_v = 1'b0;
        step(); step(); step();
        chk("drain_idle_hi", 64'(o_idle), 64'd1);
        chk("drain_cnt0", 64'(o_cnt), 64'd0);
        step();
        chk("idle_stays", 64'(o_idle), 64'd1);

        // leave drain and resume issuing
        i_drain = 1'b0;
        step();
        chk("resume_idle_lo", 64'(o_idle), 64'd0);
        issue(4'd12, 32'hC2, 1'b1); step();
        no_req(); step();
        rsp(4'd12); step();
        i_rsp_v = 1'b0;
        repeat (4) step();
        chk("final_cnt", 64'(o_cnt), 64'd0);
        chk("cmd_q_empty", 64'(cmd_q.size()), 64'd0);
        chk("cpl_q_empty", 64'(cpl_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
